// File: rtl/qed_imem_fetch_port.sv
// qed_imem_fetch_port
//   Read side of the QED instruction-memory write stream. A DEPTH-word store
//   is filled by qed_mem_shim writes and serves the core fetch port with a
//   1-cycle synchronous read. A per-slot written bit masks stale data, so
//   fetches of unwritten slots return NOP_INSTR with fetch_hit_o=0.
//   Fetch/hole/fill statistics are kept for the formal harness.
//
// Config macro: QED_FETCH_BYPASS_EN
//   defined   : a same-edge write+fetch to one index returns wr_data_i, hit=1
//   undefined : read-first, the fetch sees the slot's pre-write state
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   wr_en_i/addr/data   write stream (byte address, index = addr[AW+1:2])
//   fetch_en_i/addr     fetch strobe and byte address; fetch_en_i=0 holds outputs
//   fetch_instr_o/hit_o registered fetch result
//   fill_count_o        number of written slots (0..DEPTH)
//   fetch_count_o       accepted fetches, saturating
//   hole_count_o        accepted fetches that missed, saturating
module qed_imem_fetch_port #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [31:0]              wr_addr_i,
  input  logic [31:0]              wr_data_i,
  input  logic                     fetch_en_i,
  input  logic [31:0]              fetch_addr_i,
  output logic [31:0]              fetch_instr_o,
  output logic                     fetch_hit_o,
  output logic [$clog2(DEPTH):0]   fill_count_o,
  output logic [CNT_W-1:0]         fetch_count_o,
  output logic [CNT_W-1:0]         hole_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [AW:0]      FILL_ONE = {{AW{1'b0}}, 1'b1};

  logic [31:0]      r_mem [DEPTH];
  logic [DEPTH-1:0] r_written;
  logic [AW:0]      r_fill;
  logic [31:0]      r_instr;
  logic             r_hit;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_hole_cnt;

  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_fe_idx;
  logic [31:0]      w_rd_word;
  logic             w_rd_hit;
  logic             w_new_slot;
  logic             w_unused;

  // Byte offset and bits above the index are ignored: addresses wrap.
  assign w_wr_idx = wr_addr_i[AW+1:2];
  assign w_fe_idx = fetch_addr_i[AW+1:2];
  assign w_unused = ^{wr_addr_i[31:AW+2], wr_addr_i[1:0],
                      fetch_addr_i[31:AW+2], fetch_addr_i[1:0]};

  // Only the first write to a slot grows the fill count.
  assign w_new_slot = wr_en_i & ~r_written[w_wr_idx];

  always_comb begin
    w_rd_hit  = r_written[w_fe_idx];
    w_rd_word = w_rd_hit ? r_mem[w_fe_idx] : NOP_INSTR;
`ifdef QED_FETCH_BYPASS_EN
    // Write-first: forward the word landing on this edge.
    if (wr_en_i && (w_wr_idx == w_fe_idx)) begin
      w_rd_hit  = 1'b1;
      w_rd_word = wr_data_i;
    end
`endif
  end

  // Data array carries no reset; the written bits mask whatever it holds.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) r_mem[w_wr_idx] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_written   <= '0;
      r_fill      <= '0;
      r_instr     <= NOP_INSTR;
      r_hit       <= 1'b0;
      r_fetch_cnt <= '0;
      r_hole_cnt  <= '0;
    end else begin
      if (wr_en_i) begin
        r_written[w_wr_idx] <= 1'b1;
        if (w_new_slot) r_fill <= r_fill + FILL_ONE;
      end
      if (fetch_en_i) begin
        r_instr <= w_rd_word;
        r_hit   <= w_rd_hit;
        if (r_fetch_cnt != CNT_MAX) r_fetch_cnt <= r_fetch_cnt + CNT_ONE;
        if (!w_rd_hit && (r_hole_cnt != CNT_MAX)) r_hole_cnt <= r_hole_cnt + CNT_ONE;
      end
    end
  end

  assign fetch_instr_o = r_instr;
  assign fetch_hit_o   = r_hit;
  assign fill_count_o  = r_fill;
  assign fetch_count_o = r_fetch_cnt;
  assign hole_count_o  = r_hole_cnt;

endmodule

// File: tb/tb_qed_imem_fetch_port.sv
module tb_qed_imem_fetch_port;
  localparam int          DEPTH = 32;
  localparam int          CNT_W = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0, wr_en_i = 1'b0, fetch_en_i = 1'b0;
  logic [31:0] wr_addr_i = '0, wr_data_i = '0, fetch_addr_i = '0;
  logic [31:0] fetch_instr_o;
  logic        fetch_hit_o;
  logic [5:0]  fill_count_o;
  logic [CNT_W-1:0] fetch_count_o, hole_count_o;

  qed_imem_fetch_port #(.DEPTH(DEPTH), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .fetch_en_i(fetch_en_i), .fetch_addr_i(fetch_addr_i),
    .fetch_instr_o(fetch_instr_o), .fetch_hit_o(fetch_hit_o),
    .fill_count_o(fill_count_o), .fetch_count_o(fetch_count_o),
    .hole_count_o(hole_count_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        hit;
    int          fcnt;
    int          hcnt;
    int          fill;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: plain arrays indexed by word slot.
  logic [31:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  logic [31:0] m_instr = NOP;
  logic        m_hit = 1'b0;
  int          m_fc = 0, m_hc = 0;

  function automatic int slot(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every committed edge has one expected entry; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("instr", fetch_instr_o, e.instr);
      chk("hit",   fetch_hit_o,   e.hit);
      chk("fetch_count", fetch_count_o, e.fcnt);
      chk("hole_count",  hole_count_o,  e.hcnt);
      chk("fill_count",  fill_count_o,  e.fill);
    end
  end

  // Drive one cycle, advance the model, push the post-edge expectation.
  task automatic step(input bit rst, input bit we, input logic [31:0] wa,
                      input logic [31:0] wd, input bit fe, input logic [31:0] fa);
    exp_t e;
    int   n;
    rst_i = rst; wr_en_i = we; wr_addr_i = wa; wr_data_i = wd;
    fetch_en_i = fe; fetch_addr_i = fa;
    if (rst) begin
      foreach (m_wr[i]) m_wr[i] = 1'b0;
      m_instr = NOP; m_hit = 1'b0; m_fc = 0; m_hc = 0;
    end else begin
      if (fe) begin
        if (m_wr[slot(fa)]) begin m_instr = m_mem[slot(fa)]; m_hit = 1'b1; end
        else                begin m_instr = NOP;             m_hit = 1'b0; end
`ifdef QED_FETCH_BYPASS_EN
        if (we && slot(wa) == slot(fa)) begin m_instr = wd; m_hit = 1'b1; end
`endif
        if (m_fc < CMAX) m_fc++;
        if (!m_hit && m_hc < CMAX) m_hc++;
      end
      if (we) begin m_mem[slot(wa)] = wd; m_wr[slot(wa)] = 1'b1; end
    end
    n = 0;
    foreach (m_wr[i]) n += int'(m_wr[i]);
    e.instr = m_instr; e.hit = m_hit; e.fcnt = m_fc; e.hcnt = m_hc; e.fill = n;
    @(posedge clk);
    #1;
    q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, '0);
  endtask

  initial begin
    @(posedge clk); #1;
    // 1: reset, then fetch of an unwritten slot
    step(1, 0, '0, '0, 0, '0);
    step(0, 0, '0, '0, 1, 32'h0);
    // 2: write then fetch next cycle
    step(0, 1, 32'h4, 32'h0050_0093, 0, '0);
    step(0, 0, '0, '0, 1, 32'h4);
    // 3: wrapped fetch address 0x88 -> slot 2
    step(0, 1, 32'h8, 32'hAAAA_0001, 0, '0);
    step(0, 0, '0, '0, 1, 32'h88);
    // 4: same-edge write+fetch on unwritten slot, then refetch
    step(0, 1, 32'hC, 32'h1234_5678, 1, 32'hC);
    step(0, 0, '0, '0, 1, 32'hC);
    // rewrite of a written slot: data replaced, fill unchanged
    step(0, 1, 32'h4, 32'hDEAD_BEEF, 1, 32'h4);
    step(0, 0, '0, '0, 1, 32'h104);
    // 5: fill every slot while fetching, reset mid-stream (write ignored)
    for (int i = 0; i < DEPTH; i++)
      step(0, 1, 32'(i * 4), $urandom, 1, 32'($urandom));
    step(1, 1, 32'h10, 32'h5555_5555, 1, 32'h10);
    step(0, 0, '0, '0, 1, 32'h10);
    step(0, 0, '0, '0, 1, 32'h0);
    // random traffic with occasional holds and resets
    for (int i = 0; i < 1500; i++)
      step(($urandom % 200) == 0, $urandom % 2, $urandom, $urandom,
           ($urandom % 10) < 7, $urandom);
    // 6: saturation; no writes so every fetch is also a hole
    step(1, 0, '0, '0, 0, '0);
    while (m_fc < CMAX - 1) step(0, 0, '0, '0, 1, $urandom);
    repeat (3) step(0, 0, '0, '0, 1, $urandom);
    step(0, 1, 32'h20, 32'h0BAD_F00D, 1, 32'h20);
    repeat (4) step(0, $urandom % 2, $urandom, $urandom, 0, $urandom);
    step(0, 0, '0, '0, 1, 32'h20);
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
